mem_sweep_ctrl: RTL

Sweep controller that drives the single-clock block-RAM stage's read and write address and data ports, and consumes its registered read data. It has two jobs: filling memory with a deterministic pattern, and producing a readback signature of the full contents. The signature is used to confirm a bitstream memory re-initialisation. The stage writes on every clock, so when the block is not filling it writes back the data it just read, which leaves contents unchanged.

---
 rtl/mem_sweep_ctrl_if.sv | 30 +++
 rtl/mem_sweep_ctrl.sv | 139 +++++++++++++
 2 files changed

// File: rtl/mem_sweep_ctrl_if.sv
// Memory-stage and control signals of the sweep controller; master is the controller side.
// No flow control: the RAM stage accepts a read and a write address on every clock.
`timescale 1ns/1ps
interface mem_sweep_ctrl_if #(
  parameter int WID_MEM = 36,
  parameter int ADDR_W  = 11
);
  logic               start;
  logic               mode;
  logic [WID_MEM-1:0] fill_base;
  logic [WID_MEM-1:0] expected_sig;
  logic [ADDR_W-1:0]  raddr;
  logic [ADDR_W-1:0]  waddr;
  logic [WID_MEM-1:0] din;
  logic [WID_MEM-1:0] dout;
  logic               busy;
  logic               done;
  logic               match;
  logic [WID_MEM-1:0] signature;

  modport master (
    input  start, mode, fill_base, expected_sig, dout,
    output raddr, waddr, din, busy, done, match, signature
  );

  modport slave (
    output start, mode, fill_base, expected_sig, dout,
    input  raddr, waddr, din, busy, done, match, signature
  );
endinterface

// File: rtl/mem_sweep_ctrl.sv
// Fills a block RAM with base+k or folds its contents into a rotate-XOR signature.
// Done pulses DEPTH_MEM+1 (fill) / DEPTH_MEM+2 (scan) cycles after start; no backpressure, start ignored while busy.
`timescale 1ns/1ps
module mem_sweep_ctrl #(
  parameter int WID_MEM   = 36,
  parameter int DEPTH_MEM = 2048,
  parameter int ADDR_W    = 11
) (
  input  logic            clk_i,
  input  logic            reset_ni,
  mem_sweep_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_SCAN,
    ST_DRAIN,
    ST_DONE
  } state_e;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH_MEM - 1);

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0]  rd_addr_q, rd_addr_d;
  logic [ADDR_W-1:0]  rd_addr_dly_q;
  logic               vld_q;
  logic [WID_MEM-1:0] base_q, base_d;
  logic [WID_MEM-1:0] sig_q, sig_d;
  logic               match_q, match_d;
  logic               was_fill_q, was_fill_d;

  logic [ADDR_W-1:0]  waddr_c;
  logic [WID_MEM-1:0] din_c;
  logic               busy_c;
  logic               done_c;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rd_addr_d  = rd_addr_q;
    base_d     = base_q;
    sig_d      = sig_q;
    match_d    = match_q;
    was_fill_d = was_fill_q;
    // Outside FILL the stage rewrites what it read last cycle, keeping contents intact.
    waddr_c    = rd_addr_dly_q;
    din_c      = bus.dout;
    busy_c     = 1'b0;
    done_c     = 1'b0;

    if (vld_q) begin
      sig_d = {sig_q[WID_MEM-2:0], sig_q[WID_MEM-1]} ^ bus.dout;
    end

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          cnt_d     = '0;
          rd_addr_d = '0;
          if (bus.mode) begin
            base_d     = bus.fill_base;
            was_fill_d = 1'b1;
            state_d    = ST_FILL;
          end else begin
            sig_d      = '0;
            was_fill_d = 1'b0;
            state_d    = ST_SCAN;
          end
        end
      end
      ST_FILL: begin
        busy_c  = 1'b1;
        waddr_c = cnt_q;
        din_c   = base_q + WID_MEM'(cnt_q);
        if (cnt_q == LAST_ADDR) begin
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_SCAN: begin
        busy_c = 1'b1;
        if (cnt_q == LAST_ADDR) begin
          state_d = ST_DRAIN;
        end else begin
          cnt_d     = cnt_q + 1'b1;
          rd_addr_d = cnt_q + 1'b1;
        end
      end
      ST_DRAIN: begin
        busy_c  = 1'b1;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        done_c  = 1'b1;
        match_d = was_fill_q ? 1'b0 : (sig_q == bus.expected_sig);
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      rd_addr_q     <= '0;
      rd_addr_dly_q <= '0;
      vld_q         <= 1'b0;
      base_q        <= '0;
      sig_q         <= '0;
      match_q       <= 1'b0;
      was_fill_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      rd_addr_q     <= rd_addr_d;
      rd_addr_dly_q <= rd_addr_q;
      vld_q         <= (state_q == ST_SCAN);
      base_q        <= base_d;
      sig_q         <= sig_d;
      match_q       <= match_d;
      was_fill_q    <= was_fill_d;
    end
  end

  assign bus.raddr     = rd_addr_q;
  assign bus.waddr     = waddr_c;
  assign bus.din       = din_c;
  assign bus.busy      = busy_c;
  assign bus.done      = done_c;
  assign bus.match     = match_q;
  assign bus.signature = sig_q;

endmodule
